// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin mux arbiter.
//   - arb_state_t : FSM state encoding (IDLE, GRANT_A, GRANT_B)
//   - side_t      : identifies a requester, used to remember the last winner
//   - DEF_WIDTH / DEF_MAX_HOLD : default parameter values
package mux_arb_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_MAX_HOLD = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_A = 2'b01,
        GRANT_B = 2'b10
    } arb_state_t;

    typedef enum logic {
        SIDE_A = 1'b0,
        SIDE_B = 1'b1
    } side_t;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Bundle of request/data/grant/output signals between two sources and the
// round-robin mux arbiter.
//   master : the source side (drives req_*/data_*, observes grants and output)
//   slave  : the arbiter (observes req_*/data_*, drives grants, sel, output)
interface mux_rr_arbiter_if
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             req_a;
    logic             req_b;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic             gnt_a;
    logic             gnt_b;
    logic             sel;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;

    modport master (
        output req_a, req_b, data_a, data_b,
        input  gnt_a, gnt_b, sel, out_valid, out_data
    );

    modport slave (
        input  req_a, req_b, data_a, data_b,
        output gnt_a, gnt_b, sel, out_valid, out_data
    );
endinterface

// File: rtl/mux_rr_arbiter_mux2_w.sv
// WIDTH-wide 2:1 multiplexer used as the shared datapath.
//   a, b : data inputs
//   sel  : 0 selects a, 1 selects b
//   out  : selected data (combinational)
module mux2_w #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign out[gi] = sel ? b[gi] : a[gi];
        end
    endgenerate
endmodule

// File: rtl/mux_rr_arbiter.sv
// Two-requester round-robin arbiter owning the select of a shared 2:1 mux.
// The selected data is registered with a valid flag one cycle after each
// transfer. Grant tenure is bounded by MAX_HOLD while the other side waits.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : slave view of mux_rr_arbiter_if (req/data in, gnt/sel/out out)
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic            clk,
    input  logic            reset,
    mux_rr_arbiter_if.slave bus
);
    // Counter value at which a contested grant must rotate.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    arb_state_t       state_reg, state_next;
    logic [7:0]       hold_cnt_reg, hold_cnt_next;
    side_t            last_winner_reg, last_winner_next;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic [WIDTH-1:0] mux_out;
    logic             gnt_a, gnt_b, sel, beat;

    // State register, tenure tracking and registered output beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            hold_cnt_reg    <= 8'd0;
            last_winner_reg <= SIDE_B;   // A wins the first tie
            out_valid_reg   <= 1'b0;
            out_data_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            hold_cnt_reg    <= hold_cnt_next;
            last_winner_reg <= last_winner_next;
            out_valid_reg   <= beat;
            if (beat) begin
                out_data_reg <= mux_out;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.req_a && bus.req_b) begin
                    state_next = (last_winner_reg == SIDE_A) ? GRANT_B : GRANT_A;
                end else if (bus.req_a) begin
                    state_next = GRANT_A;
                end else if (bus.req_b) begin
                    state_next = GRANT_B;
                end
            end
            GRANT_A: begin
                if (!bus.req_a) begin
                    state_next = bus.req_b ? GRANT_B : IDLE;
                end else if (bus.req_b && hold_cnt_reg == HOLD_LAST) begin
                    state_next = GRANT_B;
                end
            end
            GRANT_B: begin
                if (!bus.req_b) begin
                    state_next = bus.req_a ? GRANT_A : IDLE;
                end else if (bus.req_a && hold_cnt_reg == HOLD_LAST) begin
                    state_next = GRANT_A;
                end
            end
            default: state_next = IDLE;
        endcase

        // Entering a grant restarts tenure; staying counts up and saturates
        // so an uncontested owner never wraps back into a long tenure.
        hold_cnt_next    = hold_cnt_reg;
        last_winner_next = last_winner_reg;
        if (state_next != state_reg && state_next != IDLE) begin
            hold_cnt_next    = 8'd0;
            last_winner_next = (state_next == GRANT_B) ? SIDE_B : SIDE_A;
        end else if (state_next == state_reg && state_reg != IDLE &&
                     hold_cnt_reg != HOLD_LAST) begin
            hold_cnt_next = hold_cnt_reg + 8'd1;
        end
    end

    // Output decode from the registered state.
    always_comb begin
        gnt_a = (state_reg == GRANT_A);
        gnt_b = (state_reg == GRANT_B);
        sel   = (state_reg == GRANT_B);
        beat  = (gnt_a && bus.req_a) || (gnt_b && bus.req_b);
    end

    mux2_w #(
        .WIDTH (WIDTH)
    ) u_mux (
        .a   (bus.data_a),
        .b   (bus.data_b),
        .sel (sel),
        .out (mux_out)
    );

    assign bus.gnt_a     = gnt_a;
    assign bus.gnt_b     = gnt_b;
    assign bus.sel       = sel;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
endmodule
